hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It produces the 2-bit operand-forwarding selects consumed by the execute-stage 3:1 operand muxes (00 register file, 01 writeback result, 10 memory-stage ALU result). It also produces stall and flush controls for all pipeline registers. A registered FSM tracks data-memory wait states, detects memory timeouts and counts stall cycles for performance monitoring.

---
 rtl/hazard_unit.sv | 113 +++++++++++
 tb/tb_hazard_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// memory-wait stalls, branch flushes, memory timeout and stall-cycle counting.
module hazard_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 LoadE,
   input  logic                 PCSrcE,
   input  logic                 MemReqM,
   input  logic                 MemReadyM,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic                 MemTimeout,
   output logic [CNT_WIDTH-1:0] StallCount
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

   state_t                r_state, w_state_nxt;
   logic [15:0]           r_wait_cnt, w_wait_cnt_nxt;
   logic                  r_timeout;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;
   logic                  w_mem_stall, w_lw_stall, w_timeout_set;

   // Memory-stage result (10) takes precedence over writeback (01).
   always_comb begin
      ForwardAE = 2'b00;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
      ForwardBE = 2'b00;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
   end

   assign w_mem_stall = MemReqM && !MemReadyM;
   assign w_lw_stall  = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

   // A memory wait freezes everything upstream, so branch and load-use
   // decisions are re-evaluated once memory completes.
   always_comb begin
      StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
      FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
      if (w_mem_stall) begin
         StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1; FlushE = 1'b1;
      end else if (w_lw_stall) begin
         StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_set  = 1'b0;
      case (r_state)
         RUN: if (w_mem_stall) begin
            w_state_nxt    = MEM_WAIT;
            w_wait_cnt_nxt = 16'd1;
         end
         MEM_WAIT: if (w_mem_stall) begin
            w_timeout_set = (r_wait_cnt == TIMEOUT_VAL);
            if (r_wait_cnt != 16'hFFFF) w_wait_cnt_nxt = r_wait_cnt + 16'd1;
         end else begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = 16'd0;
         end
         default: begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RUN;
         r_wait_cnt  <= 16'd0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_timeout_set) r_timeout <= 1'b1;
         if (StallF) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
   end

   assign MemTimeout = r_timeout;
   assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a behavioural model
// that tracks memory-stall run length rather than FSM state.
module tb_hazard_unit;

   localparam int T  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic          MemTimeout;
   logic [CW-1:0] StallCount;

   hazard_unit #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemTimeout(MemTimeout), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: length of the current unbroken run of memory-stall cycles,
   // sticky timeout flag and stall-cycle count.
   int m_run = 0;
   bit m_to  = 1'b0;
   int m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Expected controls as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   function automatic logic [6:0] ctl();
      bit ms, lw;
      ms = MemReqM && !MemReadyM;
      lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (ms)     return 7'b1111_001;
      if (PCSrcE) return 7'b0000_110;
      if (lw)     return 7'b1100_010;
      return 7'b0000_000;
   endfunction

   task automatic check_all();
      logic [6:0] e;
      e = ctl();
      chk("ForwardAE", 32'(ForwardAE), 32'(fwd(Rs1E)));
      chk("ForwardBE", 32'(ForwardBE), 32'(fwd(Rs2E)));
      chk("ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(e));
      chk("MemTimeout", 32'(MemTimeout), 32'(m_to));
      chk("StallCount", 32'(StallCount), 32'(m_cnt));
   endtask

   task automatic step();
      logic [6:0] e;
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (!reset) begin
         e = ctl();
         if (e[6]) m_cnt = (m_cnt + 1) % (1 << CW);
         m_run = (MemReqM && !MemReadyM) ? m_run + 1 : 0;
         if (m_run == T + 1) m_to = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      m_run = 0; m_to = 1'b0; m_cnt = 0;
      chk("rst_timeout", 32'(MemTimeout), 32'd0);
      chk("rst_count", 32'(StallCount), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      idle();
      #2;
      chk("init_timeout", 32'(MemTimeout), 32'd0);
      chk("init_count", 32'(StallCount), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Forwarding priority
      RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
      #1 chk("fwd_M_A", 32'(ForwardAE), 32'd2); chk("fwd_M_B", 32'(ForwardBE), 32'd2);
      step();
      RegWriteM = 0;
      #1 chk("fwd_W_A", 32'(ForwardAE), 32'd1); chk("fwd_W_B", 32'(ForwardBE), 32'd1);
      step();
      RdM = 0; RdW = 0; RegWriteM = 1;
      #1 chk("fwd_x0_A", 32'(ForwardAE), 32'd0); chk("fwd_x0_B", 32'(ForwardBE), 32'd0);
      step();

      // Load-use
      idle(); LoadE = 1; RdE = 7; Rs2D = 7;
      #1 chk("lw_stall", 32'({StallF, StallD, FlushE}), 32'd7);
      step();
      chk("lw_count", 32'(StallCount), 32'd1);
      RdE = 0;
      #1 chk("lw_x0", 32'({StallF, StallD, FlushE}), 32'd0);
      step();

      // Branch flush, then branch held by a memory wait
      idle(); PCSrcE = 1; LoadE = 1; RdE = 3; Rs1D = 3;
      #1 chk("br_flush", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
      step();
      MemReqM = 1;
      #1 chk("br_mem", 32'({FlushD, FlushE, StallF, StallD, StallE, StallM, FlushW}), 32'b0011111);
      step();
      idle();
      step();

      // Three-cycle memory wait
      do_reset();
      MemReqM = 1;
      repeat (3) step();
      MemReadyM = 1;
      #1 chk("wait_done", 32'(StallF), 32'd0);
      step();
      chk("wait_count", 32'(StallCount), 32'd3);
      chk("wait_noto", 32'(MemTimeout), 32'd0);

      // Timeout, sticky across ready, then async reset mid-wait
      do_reset();
      MemReqM = 1; MemReadyM = 0;
      repeat (4) step();
      chk("to_early", 32'(MemTimeout), 32'd0);
      step();
      chk("to_set", 32'(MemTimeout), 32'd1);
      MemReadyM = 1;
      step();
      MemReadyM = 0;
      repeat (4) step();
      chk("to_sticky", 32'(MemTimeout), 32'd1);
      chk("cnt_9", 32'(StallCount), 32'd9);
      #2 reset = 1'b1;
      #1;
      chk("async_to", 32'(MemTimeout), 32'd0);
      chk("async_cnt", 32'(StallCount), 32'd0);
      m_run = 0; m_to = 1'b0; m_cnt = 0;
      idle();
      @(negedge clk) reset = 1'b0;
      step();
      MemReqM = 1;
      repeat (5) step();
      chk("to_rearm", 32'(MemTimeout), 32'd1);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         LoadE = 1'($urandom); PCSrcE = ($urandom % 4) == 0;
         MemReqM = 1'($urandom); MemReadyM = ($urandom % 4) == 0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
